// File: rtl/tx_fifo_feeder.sv
// Byte FIFO that feeds a UART transmitter one frame at a time: pop the head
// byte, pulse o_tx_start for one cycle, then hold until the done tick.
module tx_fifo_feeder #(
  parameter int NB_DATA = 8,
  parameter int ADDR_W  = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_tx_done_tick,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_overflow,
  output logic               o_busy
);

  // state    | meaning
  // ST_IDLE  | no frame in flight; pop head byte when FIFO is non-empty
  // ST_START | byte latched on o_tx_data, o_tx_start pulsed this cycle
  // ST_WAIT  | frame in flight, waiting for i_tx_done_tick
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [NB_DATA-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic [NB_DATA-1:0] r_tx_data;
  state_t             r_state;
  state_t             w_state_next;
  logic               w_wr_accept;
  logic               w_pop;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_tx_data  = r_tx_data;
  // A full FIFO drops the write even when a pop frees a slot this cycle.
  assign w_wr_accept = i_wr & ~o_full & ~i_reset;
  assign o_overflow  = i_wr & o_full & ~i_reset;

  always_ff @(posedge i_clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_data <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_tx_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (!o_empty) w_state_next = ST_START;
      ST_START: w_state_next = ST_WAIT;
      ST_WAIT:  if (i_tx_done_tick) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_start = 1'b0;
    o_busy     = 1'b1;
    w_pop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        w_pop  = ~o_empty;
      end
      ST_START: o_tx_start = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Directed bench for tx_fifo_feeder: latency, ordering, overflow, wrap and
// mid-frame reset, with hand-computed expectations.
module tb_tx_fifo_feeder;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_wr;
  logic [7:0] i_wr_data;
  logic       i_tx_done_tick;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;
  logic       o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] got_q[$];
  int         start_cyc_q[$];
  logic [7:0] exp_q[$];

  tx_fifo_feeder #(.NB_DATA(8), .ADDR_W(2)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_wr           (i_wr),
    .i_wr_data      (i_wr_data),
    .i_tx_done_tick (i_tx_done_tick),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_overflow     (o_overflow),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Every start pulse is recorded with its byte and cycle number.
  always @(negedge i_clk) begin
    if (o_tx_start === 1'b1) begin
      got_q.push_back(o_tx_data);
      start_cyc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    i_wr      = 1'b1;
    i_wr_data = d;
    step();
    i_wr      = 1'b0;
  endtask

  task automatic done_pulse();
    i_tx_done_tick = 1'b1;
    step();
    i_tx_done_tick = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int i;
    i = 0;
    while (got_q.size() < n && i < 200) begin
      step();
      i++;
    end
    check_eq("start_wait", 32'(got_q.size() >= n), 1);
  endtask

  task automatic check_seq(input string tag);
    int n;
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq(tag, got_q[i], exp_q[i]);
  endtask

  task automatic clear_log();
    got_q.delete();
    start_cyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int j;
    int s;
    int n_before;

    // Reset with a write strobe held high: nothing may be accepted.
    i_reset        = 1'b1;
    i_wr           = 1'b1;
    i_wr_data      = 8'hFF;
    i_tx_done_tick = 1'b0;
    repeat (3) step();
    check_eq("rst_empty",    o_empty,    1);
    check_eq("rst_full",     o_full,     0);
    check_eq("rst_busy",     o_busy,     0);
    check_eq("rst_start",    o_tx_start, 0);
    check_eq("rst_data",     o_tx_data,  0);
    check_eq("rst_overflow", o_overflow, 0);
    i_reset = 1'b0;
    i_wr    = 1'b0;
    step();
    check_eq("post_rst_empty", o_empty, 1);

    // Single byte latency: write in k, non-empty in k+1, start in k+2.
    clear_log();
    k = cyc;
    write_byte(8'hA5);
    check_eq("a5_empty_k1", o_empty,    0);
    check_eq("a5_start_k1", o_tx_start, 0);
    step();
    check_eq("a5_start_k2", o_tx_start, 1);
    check_eq("a5_cycle",    cyc - k,    2);
    check_eq("a5_data",     o_tx_data,  8'hA5);
    check_eq("a5_busy",     o_busy,     1);
    step();
    check_eq("a5_start_k3", o_tx_start, 0);
    check_eq("a5_busy_k3",  o_busy,     1);
    repeat (4) step();
    check_eq("a5_start_wait", o_tx_start, 0);
    done_pulse();
    check_eq("a5_idle_busy", o_busy, 0);

    // Three back-to-back writes, done tick 20 cycles after each start.
    clear_log();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    for (int f = 0; f < 3; f++) begin
      wait_starts(f + 1);
      if (got_q.size() > f) begin
        s = start_cyc_q[f];
        while (cyc < s + 20) step();
        check_eq("b2b_hold_data", o_tx_data, 8'(f + 1));
        j = cyc;
        done_pulse();
        if (f < 2) begin
          wait_starts(f + 2);
          if (got_q.size() > f + 1) check_eq("b2b_gap", start_cyc_q[f + 1] - j, 2);
        end
      end
    end
    repeat (4) step();
    exp_q = {8'h01, 8'h02, 8'h03};
    check_seq("b2b_order");

    // Hold the FSM in WAIT and overfill the FIFO by one.
    clear_log();
    write_byte(8'h30);
    wait_starts(1);
    for (int i = 0; i < 5; i++) begin
      i_wr      = 1'b1;
      i_wr_data = 8'h31 + 8'(i);
      #1;
      check_eq("ovf_flag", o_overflow, (i == 4) ? 1 : 0);
      step();
      i_wr = 1'b0;
      if (i == 3) check_eq("ovf_full_after4", o_full, 1);
    end
    check_eq("ovf_still_full", o_full, 1);
    for (int f = 0; f < 5; f++) begin
      repeat (3) step();
      done_pulse();
      if (f < 4) wait_starts(f + 2);
    end
    repeat (5) step();
    exp_q = {8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    check_seq("ovf_order");
    check_eq("ovf_drain_empty", o_empty, 1);
    check_eq("ovf_drain_busy",  o_busy,  0);

    // Full FIFO in IDLE: a write in the pop cycle is still dropped.
    clear_log();
    write_byte(8'h40);
    wait_starts(1);
    write_byte(8'h41);
    write_byte(8'h42);
    write_byte(8'h43);
    write_byte(8'h44);
    check_eq("popw_full", o_full, 1);
    done_pulse();
    check_eq("popw_idle", o_busy, 0);
    i_wr      = 1'b1;
    i_wr_data = 8'h45;
    #1;
    check_eq("popw_overflow", o_overflow, 1);
    step();
    i_wr = 1'b0;
    check_eq("popw_full_after", o_full,     0);
    check_eq("popw_empty_after", o_empty,   0);
    check_eq("popw_start",      o_tx_start, 1);
    check_eq("popw_data",       o_tx_data,  8'h41);
    for (int f = 0; f < 4; f++) begin
      repeat (3) step();
      done_pulse();
      if (f < 3) wait_starts(f + 3);
    end
    repeat (5) step();
    exp_q = {8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    check_seq("popw_order");

    // Ten bytes with interleaved writes, pointers wrap twice.
    clear_log();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      write_byte(8'h10 + 8'(k));
      k++;
    end
    for (int f = 0; f < 10; f++) begin
      wait_starts(f + 1);
      if (k < 10) begin
        write_byte(8'h10 + 8'(k));
        k++;
      end
      repeat (2) step();
      done_pulse();
    end
    repeat (5) step();
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    check_seq("wrap_order");
    check_eq("wrap_empty", o_empty, 1);

    // Reset mid-frame with two bytes stored.
    clear_log();
    write_byte(8'h50);
    wait_starts(1);
    write_byte(8'h51);
    write_byte(8'h52);
    step();
    check_eq("midrst_pre_busy",  o_busy,  1);
    check_eq("midrst_pre_empty", o_empty, 0);
    #2;
    i_reset   = 1'b1;
    i_wr      = 1'b1;
    i_wr_data = 8'h77;
    #1;
    check_eq("midrst_busy",     o_busy,     0);
    check_eq("midrst_empty",    o_empty,    1);
    check_eq("midrst_full",     o_full,     0);
    check_eq("midrst_start",    o_tx_start, 0);
    check_eq("midrst_data",     o_tx_data,  0);
    check_eq("midrst_overflow", o_overflow, 0);
    repeat (2) step();
    i_reset = 1'b0;
    i_wr    = 1'b0;
    n_before = got_q.size();
    repeat (30) step();
    check_eq("midrst_no_start", got_q.size(), n_before);
    check_eq("midrst_idle",     o_busy,       0);
    check_eq("midrst_empty2",   o_empty,      1);
    write_byte(8'h60);
    wait_starts(2);
    exp_q = {8'h50, 8'h60};
    check_seq("midrst_order");
    repeat (3) step();
    done_pulse();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_fifo_feeder.md
TX_FIFO_FEEDER -- requirements
Module: tx_fifo_feeder

Interface
REQ-001 Parameter NB_DATA, default 8, SHALL set the byte width of stored and transmitted data.
REQ-002 Parameter ADDR_W, default 2, SHALL set FIFO depth to 2**ADDR_W entries.
REQ-003 i_clk  in  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 i_reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 i_wr  in  1  SHALL be the write strobe; one byte is offered per cycle it is high.
REQ-006 i_wr_data  in  NB_DATA  SHALL be the byte offered with i_wr.
REQ-007 i_tx_done_tick  in  1  SHALL be the one-cycle end-of-frame pulse from the downstream UART transmitter.
REQ-008 o_tx_start  out  1  SHALL request the downstream transmitter to start a frame.
REQ-009 o_tx_data  out  NB_DATA  SHALL carry the byte to transmit.
REQ-010 o_full  out  1  SHALL indicate all FIFO entries are occupied.
REQ-011 o_empty  out  1  SHALL indicate no FIFO entries are occupied.
REQ-012 o_overflow  out  1  SHALL pulse when a write is dropped.
REQ-013 o_busy  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 Storage SHALL be a circular buffer with ADDR_W-bit read/write pointers wrapping from 2**ADDR_W-1 to 0, plus an (ADDR_W+1)-bit occupancy count.
REQ-015 o_full SHALL equal (count == 2**ADDR_W); o_empty SHALL equal (count == 0); both derive from registered count only.
REQ-016 A write SHALL be accepted when i_wr=1 and o_full=0: data stored at write pointer, pointer incremented.
REQ-017 A write with o_full=1 SHALL be dropped, even if a pop occurs the same cycle; o_overflow SHALL equal i_wr & o_full in that cycle.
REQ-018 The FSM SHALL have states IDLE, START, WAIT.
REQ-019 IDLE: if o_empty=0, SHALL pop the head entry (read pointer increments), register it into o_tx_data, go to START; else stay.
REQ-020 START: o_tx_start SHALL be 1 for exactly this one cycle; next state WAIT unconditionally.
REQ-021 WAIT: o_tx_start SHALL be 0; on i_tx_done_tick=1 go to IDLE, else stay.
REQ-022 o_tx_start SHALL be 0 in every state other than START.
REQ-023 o_tx_data SHALL stay constant from entry into START until the next pop.
REQ-024 i_tx_done_tick SHALL be ignored in IDLE and START.
REQ-025 Accepted write and pop in the same cycle SHALL leave count unchanged; write alone +1; pop alone -1.
REQ-026 Latency: byte written in cycle k into an empty FIFO with FSM in IDLE SHALL clear o_empty in k+1, be popped in k+1, and raise o_tx_start in k+2.
REQ-027 Back-to-back: after i_tx_done_tick in cycle j with FIFO non-empty, next o_tx_start SHALL occur in cycle j+2.
REQ-028 Bytes SHALL be presented on o_tx_data in exact write order; no byte duplicated or lost except dropped writes.
REQ-029 An illegal state encoding SHALL return to IDLE on the next clock.

Reset
REQ-030 i_reset=1 SHALL immediately force: FSM IDLE, pointers 0, count 0, o_tx_data 0, o_tx_start 0, o_empty 1, o_full 0, o_busy 0.
REQ-031 Reset mid-frame (START or WAIT) SHALL discard the in-flight byte and all stored entries; no o_tx_start until a new write after release.
REQ-032 o_overflow SHALL be 0 during reset; writes during reset SHALL be ignored.

Verification
REQ-033 Reset release, write 0xA5 at cycle k -> o_empty=0 at k+1, o_tx_start=1 only at k+2 with o_tx_data=0xA5, o_busy=1.
REQ-034 Write 0x01,0x02,0x03 back-to-back, done tick 20 cycles after each start -> three starts, data 0x01,0x02,0x03 in order, each start 2 cycles after prior done tick.
REQ-035 FSM held in WAIT, write 5 bytes into depth-4 FIFO -> o_full=1 after 4th, 5th write o_overflow=1 and dropped, 4 bytes sent afterwards.
REQ-036 Full FIFO, i_wr=1 in same cycle as IDLE pop -> write dropped, o_overflow=1, count=3.
REQ-037 Pointer wrap: 10 bytes 0x10..0x19 sent with interleaved writes -> output order 0x10..0x19 intact.
REQ-038 Assert i_reset during WAIT with 2 bytes stored -> all outputs at reset values, no o_tx_start after release without new write.
